// File: rtl/i2c_slave_rx.sv
// Oversampled I2C receive slave: START/STOP detect, 7-bit address match, ACK drive, byte strobes.
// Define I2C_SLAVE_RX_GLITCH_FILTER_EN to add a 3-sample run filter on SCL/SDA (+2 cycles latency).
module i2c_slave_rx #(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_rw,
  output logic       addr_match,
  output logic       busy,
  output logic       start_det,
  output logic       stop_det,
  output logic [7:0] byte_count
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_DATA, ST_DATA_ACK, ST_IGNORE
  } state_t;

  // Index 1 carries SCL, index 0 carries SDA through identical conditioning chains.
  logic [1:0] line_raw;
  logic [1:0] line_s;
  assign line_raw = {scl_in, sda_in};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_line
      logic [SYNC_STAGES-1:0] sync_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_reg <= '1;
        else          sync_reg <= {sync_reg[SYNC_STAGES-2:0], line_raw[gi]};
      end

`ifdef I2C_SLAVE_RX_GLITCH_FILTER_EN
      logic       sync_out;
      logic [1:0] hist_reg;
      logic       filt_reg;
      logic       filt_next;

      assign sync_out = sync_reg[SYNC_STAGES-1];

      // Output follows the input only once three consecutive samples agree.
      always_comb begin
        filt_next = filt_reg;
        if ((sync_out == hist_reg[0]) && (hist_reg[0] == hist_reg[1]))
          filt_next = sync_out;
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          hist_reg <= 2'b11;
          filt_reg <= 1'b1;
        end else begin
          hist_reg <= {hist_reg[0], sync_out};
          filt_reg <= filt_next;
        end
      end

      assign line_s[gi] = filt_next;
`else
      assign line_s[gi] = sync_reg[SYNC_STAGES-1];
`endif
    end
  endgenerate

  logic scl_s, sda_s;
  logic scl_prev_reg, sda_prev_reg;
  logic scl_rise, scl_fall;
  logic start_cond, stop_cond;

  assign scl_s = line_s[1];
  assign sda_s = line_s[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_prev_reg <= 1'b1;
      sda_prev_reg <= 1'b1;
    end else begin
      scl_prev_reg <= scl_s;
      sda_prev_reg <= sda_s;
    end
  end

  assign scl_rise   = scl_s & ~scl_prev_reg;
  assign scl_fall   = ~scl_s & scl_prev_reg;
  assign start_cond = scl_s & sda_prev_reg & ~sda_s;
  assign stop_cond  = scl_s & ~sda_prev_reg & sda_s;

  state_t     state_reg, state_next;
  logic [2:0] bit_cnt_reg;
  logic [7:0] shift_reg;
  logic [7:0] byte_in;
  logic       last_bit;

  logic       sda_oe_reg;
  logic [7:0] rx_data_reg;
  logic       rx_valid_reg;
  logic       rx_rw_reg;
  logic       addr_match_reg;
  logic       busy_reg;
  logic       start_det_reg;
  logic       stop_det_reg;
  logic [7:0] byte_count_reg;

  logic shift_en, addr_hit, data_done, ack_on, ack_off;

  assign byte_in  = {shift_reg[6:0], sda_s};
  assign last_bit = (bit_cnt_reg == 3'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  // Bus conditions take priority over every state transition.
  always_comb begin
    state_next = state_reg;
    if (stop_cond) begin
      state_next = ST_IDLE;
    end else if (start_cond) begin
      state_next = ST_ADDR;
    end else begin
      case (state_reg)
        ST_ADDR:
          if (scl_rise && last_bit)
            state_next = (byte_in[7:1] == SLAVE_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
        ST_DATA:
          if (scl_rise && last_bit) state_next = ST_DATA_ACK;
        ST_ADDR_ACK, ST_DATA_ACK:
          if (scl_fall && sda_oe_reg) state_next = ST_DATA;
        default: ;
      endcase
    end
  end

  // In the ACK states sda_oe itself marks whether the window has opened yet.
  always_comb begin
    shift_en  = 1'b0;
    addr_hit  = 1'b0;
    data_done = 1'b0;
    ack_on    = 1'b0;
    ack_off   = 1'b0;
    if (!start_cond && !stop_cond) begin
      case (state_reg)
        ST_ADDR: begin
          shift_en = scl_rise;
          addr_hit = scl_rise && last_bit && (byte_in[7:1] == SLAVE_ADDR);
        end
        ST_DATA: begin
          shift_en  = scl_rise;
          data_done = scl_rise && last_bit;
        end
        ST_ADDR_ACK, ST_DATA_ACK: begin
          ack_on  = scl_fall && !sda_oe_reg;
          ack_off = scl_fall && sda_oe_reg;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_reg    <= 3'd7;
      shift_reg      <= 8'h00;
      sda_oe_reg     <= 1'b0;
      rx_data_reg    <= 8'h00;
      rx_valid_reg   <= 1'b0;
      rx_rw_reg      <= 1'b0;
      addr_match_reg <= 1'b0;
      busy_reg       <= 1'b0;
      start_det_reg  <= 1'b0;
      stop_det_reg   <= 1'b0;
      byte_count_reg <= 8'h00;
    end else begin
      start_det_reg <= start_cond;
      stop_det_reg  <= stop_cond;
      rx_valid_reg  <= data_done;
      if (stop_cond) begin
        busy_reg       <= 1'b0;
        addr_match_reg <= 1'b0;
        sda_oe_reg     <= 1'b0;
      end else if (start_cond) begin
        busy_reg       <= 1'b1;
        addr_match_reg <= 1'b0;
        sda_oe_reg     <= 1'b0;
        bit_cnt_reg    <= 3'd7;
      end else begin
        if (shift_en) begin
          shift_reg   <= byte_in;
          bit_cnt_reg <= bit_cnt_reg - 3'd1;
        end
        if (addr_hit) begin
          rx_rw_reg      <= byte_in[0];
          byte_count_reg <= 8'h00;
          addr_match_reg <= 1'b1;
        end
        if (data_done) begin
          rx_data_reg <= byte_in;
          if (byte_count_reg != 8'hFF) byte_count_reg <= byte_count_reg + 8'd1;
        end
        if (ack_on) sda_oe_reg <= 1'b1;
        if (ack_off) begin
          sda_oe_reg  <= 1'b0;
          bit_cnt_reg <= 3'd7;
        end
      end
    end
  end

  assign sda_oe     = sda_oe_reg;
  assign rx_data    = rx_data_reg;
  assign rx_valid   = rx_valid_reg;
  assign rx_rw      = rx_rw_reg;
  assign addr_match = addr_match_reg;
  assign busy       = busy_reg;
  assign start_det  = start_det_reg;
  assign stop_det   = stop_det_reg;
  assign byte_count = byte_count_reg;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Randomized self-checking bench for i2c_slave_rx: bit-banged I2C master plus transaction-level model.
`timescale 1ns/1ps
module tb_i2c_slave_rx;
  localparam int Q = 5;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       scl_drv = 1'b1;
  logic       sda_drv = 1'b1;
  logic       scl_in, sda_in;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid, rx_rw, addr_match, busy, start_det, stop_det;
  logic [7:0] byte_count;

  // Open-drain bus: either side can pull SDA low.
  assign scl_in = scl_drv;
  assign sda_in = sda_drv & ~sda_oe;

  i2c_slave_rx #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .scl_in(scl_in), .sda_in(sda_in),
    .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid), .rx_rw(rx_rw),
    .addr_match(addr_match), .busy(busy), .start_det(start_det),
    .stop_det(stop_det), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int n_start = 0, n_stop = 0, n_oe_rise = 0;
  logic oe_prev = 1'b0;
  logic [7:0] rx_q[$];

  // Model state carried between randomized transactions.
  logic [7:0] m_count;
  logic       m_rw;

  always @(negedge clk) begin
    if (start_det) n_start++;
    if (stop_det) n_stop++;
    if (rx_valid) rx_q.push_back(rx_data);
    if (sda_oe && !oe_prev) n_oe_rise++;
    oe_prev = sda_oe;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_drv = 1'b0; cyc(2*Q); scl_drv = 1'b0; cyc(Q);
  endtask

  task automatic bus_bit(input logic b);
    sda_drv = b; cyc(Q); scl_drv = 1'b1; cyc(2*Q); scl_drv = 1'b0; cyc(Q);
  endtask

  task automatic bus_ack(output logic acked);
    sda_drv = 1'b1; cyc(Q); scl_drv = 1'b1; cyc(Q);
    acked = sda_oe;
    cyc(Q); scl_drv = 1'b0; cyc(Q);
  endtask

  task automatic bus_byte(input logic [7:0] b, output logic acked);
    for (int i = 7; i >= 0; i--) bus_bit(b[i]);
    bus_ack(acked);
  endtask

  task automatic bus_rstart();
    sda_drv = 1'b1; cyc(Q); scl_drv = 1'b1; cyc(Q); sda_drv = 1'b0; cyc(Q); scl_drv = 1'b0; cyc(Q);
  endtask

  task automatic bus_stop();
    sda_drv = 1'b0; cyc(Q); scl_drv = 1'b1; cyc(Q); sda_drv = 1'b1; cyc(2*Q);
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    chk_cnt++; if ({sda_oe, rx_valid, rx_rw, addr_match, busy, start_det, stop_det} !== 7'b0)
      $display("FAIL reset_flags: got %b want 0000000", {sda_oe, rx_valid, rx_rw, addr_match, busy, start_det, stop_det});
    else pass_cnt++;
    chk_cnt++; if ({rx_data, byte_count} !== 16'h0000)
      $display("FAIL reset_bytes: got %h want 0000", {rx_data, byte_count});
    else pass_cnt++;
    cyc(4); reset_n = 1'b1; cyc(4);
    chk_cnt++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_basic_write();
    int s0, p0, o0;
    logic a0, a1;
    s0 = n_start; p0 = n_stop; o0 = n_oe_rise; rx_q.delete();
    bus_start();
    chk_cnt++; if (n_start !== s0 + 1) $display("FAIL wr_start_pulse: got %0d want %0d", n_start - s0, 1); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b1) $display("FAIL wr_busy: got %b want 1", busy); else pass_cnt++;
    bus_byte(8'hA0, a0);
    bus_byte(8'hAA, a1);
    chk_cnt++; if ({a0, a1} !== 2'b11) $display("FAIL wr_acks: got %b want 11", {a0, a1}); else pass_cnt++;
    chk_cnt++; if (addr_match !== 1'b1) $display("FAIL wr_addr_match: got %b want 1", addr_match); else pass_cnt++;
    bus_stop();
    chk_cnt++; if (n_stop !== p0 + 1) $display("FAIL wr_stop_pulse: got %0d want 1", n_stop - p0); else pass_cnt++;
    chk_cnt++; if (n_oe_rise !== o0 + 2) $display("FAIL wr_oe_windows: got %0d want 2", n_oe_rise - o0); else pass_cnt++;
    chk_cnt++; if (rx_q.size() != 1 || rx_q[0] !== 8'hAA)
      $display("FAIL wr_rx: got %0d bytes first %h want 1 byte aa", rx_q.size(), rx_q[0]);
    else pass_cnt++;
    chk_cnt++; if (byte_count !== 8'd1) $display("FAIL wr_count: got %0d want 1", byte_count); else pass_cnt++;
    chk_cnt++; if ({busy, addr_match, rx_rw} !== 3'b000) $display("FAIL wr_after_stop: got %b want 000", {busy, addr_match, rx_rw}); else pass_cnt++;
    $display("txn write addr=a0 data=aa acks=%b%b", a0, a1);
  endtask

  task automatic test_addr_mismatch();
    int o0;
    logic a0, a1, am;
    o0 = n_oe_rise; rx_q.delete();
    bus_start();
    bus_byte(8'hA2, a0);
    bus_byte(8'h12, a1);
    am = addr_match;
    bus_stop();
    chk_cnt++; if ({a0, a1} !== 2'b00) $display("FAIL mm_acks: got %b want 00", {a0, a1}); else pass_cnt++;
    chk_cnt++; if (n_oe_rise !== o0) $display("FAIL mm_oe: got %0d want 0", n_oe_rise - o0); else pass_cnt++;
    chk_cnt++; if (rx_q.size() != 0) $display("FAIL mm_rx: got %0d bytes want 0", rx_q.size()); else pass_cnt++;
    chk_cnt++; if (am !== 1'b0) $display("FAIL mm_addr_match: got %b want 0", am); else pass_cnt++;
    chk_cnt++; if ({busy, byte_count} !== {1'b0, 8'd1}) $display("FAIL mm_idle: got busy %b count %0d want 0 1", busy, byte_count); else pass_cnt++;
    $display("txn mismatch addr=a2 data=12 acks=%b%b", a0, a1);
  endtask

  task automatic test_read_addr();
    logic a0, a1, a2;
    rx_q.delete();
    bus_start();
    bus_byte(8'hA1, a0);
    bus_byte(8'h01, a1);
    bus_byte(8'h02, a2);
    bus_stop();
    chk_cnt++; if ({a0, a1, a2} !== 3'b111) $display("FAIL rd_acks: got %b want 111", {a0, a1, a2}); else pass_cnt++;
    chk_cnt++; if (rx_rw !== 1'b1) $display("FAIL rd_rw: got %b want 1", rx_rw); else pass_cnt++;
    chk_cnt++; if (rx_q.size() != 2 || rx_q[0] !== 8'h01 || rx_q[1] !== 8'h02)
      $display("FAIL rd_rx: got %0d bytes %h %h want 01 02", rx_q.size(), rx_q[0], rx_q[1]);
    else pass_cnt++;
    chk_cnt++; if (byte_count !== 8'd2) $display("FAIL rd_count: got %0d want 2", byte_count); else pass_cnt++;
    $display("txn read addr=a1 data=01,02 acks=%b", {a0, a1, a2});
  endtask

  task automatic test_repeated_start();
    int s0;
    logic a0, a1, a2, am;
    s0 = n_start; rx_q.delete();
    bus_start();
    bus_byte(8'hA0, a0);
    for (int i = 0; i < 4; i++) bus_bit(1'($urandom_range(0, 1)));
    bus_rstart();
    am = addr_match;
    bus_byte(8'hA0, a1);
    bus_byte(8'h5A, a2);
    bus_stop();
    chk_cnt++; if (n_start !== s0 + 2) $display("FAIL rs_starts: got %0d want 2", n_start - s0); else pass_cnt++;
    chk_cnt++; if (am !== 1'b0) $display("FAIL rs_match_cleared: got %b want 0", am); else pass_cnt++;
    chk_cnt++; if (rx_q.size() != 1 || rx_q[0] !== 8'h5A)
      $display("FAIL rs_rx: got %0d bytes first %h want 1 byte 5a", rx_q.size(), rx_q[0]);
    else pass_cnt++;
    chk_cnt++; if ({rx_rw, byte_count} !== {1'b0, 8'd1}) $display("FAIL rs_rw_count: got %b %0d want 0 1", rx_rw, byte_count); else pass_cnt++;
    $display("txn rstart addr=a0 partial rstart addr=a0 data=5a acks=%b", {a0, a1, a2});
  endtask

  task automatic test_reset_mid();
    logic a0, a1, am;
    bus_start();
    bus_byte(8'hA0, a0);
    bus_bit(1'b1); bus_bit(1'b0);
    sda_drv = 1'b1; cyc(Q); scl_drv = 1'b1; cyc(Q);
    am = addr_match;
    chk_cnt++; if ({am, busy} !== 2'b11) $display("FAIL rm_pre: got %b want 11", {am, busy}); else pass_cnt++;
    #2 reset_n = 1'b0;
    #1;
    chk_cnt++; if ({sda_oe, rx_valid, rx_rw, addr_match, busy, start_det, stop_det} !== 7'b0)
      $display("FAIL rm_flags: got %b want 0000000", {sda_oe, rx_valid, rx_rw, addr_match, busy, start_det, stop_det});
    else pass_cnt++;
    chk_cnt++; if ({rx_data, byte_count} !== 16'h0000) $display("FAIL rm_bytes: got %h want 0000", {rx_data, byte_count}); else pass_cnt++;
    scl_drv = 1'b1; sda_drv = 1'b1;
    cyc(4); reset_n = 1'b1; cyc(4);
    rx_q.delete();
    bus_start();
    bus_byte(8'hA0, a0);
    bus_byte(8'hC3, a1);
    bus_stop();
    chk_cnt++; if ({a0, a1} !== 2'b11) $display("FAIL rm_acks: got %b want 11", {a0, a1}); else pass_cnt++;
    chk_cnt++; if (rx_q.size() != 1 || rx_q[0] !== 8'hC3)
      $display("FAIL rm_rx: got %0d bytes first %h want 1 byte c3", rx_q.size(), rx_q[0]);
    else pass_cnt++;
    chk_cnt++; if (byte_count !== 8'd1) $display("FAIL rm_count: got %0d want 1", byte_count); else pass_cnt++;
    $display("txn reset-mid then addr=a0 data=c3 acks=%b%b", a0, a1);
  endtask

  task automatic test_random();
    m_count = 8'd1; m_rw = 1'b0;
    for (int t = 0; t < 8; t++) begin
      logic [7:0] addr_b;
      logic [7:0] data[$];
      logic [7:0] exp_q[$];
      logic       matched, acked, am;
      int         n, ack_cnt, exp_acks;
      bit         ok;
      if (t == 0 || $urandom_range(0, 1) == 1) addr_b = {7'h50, 1'($urandom_range(0, 1))};
      else addr_b = 8'($urandom);
      n = $urandom_range(0, 3);
      data.delete();
      for (int i = 0; i < n; i++) data.push_back(8'($urandom));
      matched  = (addr_b[7:1] == 7'h50);
      exp_q.delete();
      if (matched) begin
        exp_q = data;
        m_count = (n > 255) ? 8'd255 : 8'(n);
        m_rw = addr_b[0];
      end
      exp_acks = matched ? n + 1 : 0;
      rx_q.delete();
      ack_cnt = 0;
      bus_start();
      bus_byte(addr_b, acked); if (acked) ack_cnt++;
      for (int i = 0; i < n; i++) begin bus_byte(data[i], acked); if (acked) ack_cnt++; end
      am = addr_match;
      bus_stop();
      chk_cnt++; if (ack_cnt != exp_acks) $display("FAIL rnd%0d_acks: got %0d want %0d", t, ack_cnt, exp_acks); else pass_cnt++;
      chk_cnt++; if (am !== matched) $display("FAIL rnd%0d_addr_match: got %b want %b", t, am, matched); else pass_cnt++;
      ok = (rx_q.size() == exp_q.size());
      for (int i = 0; i < exp_q.size() && ok; i++) if (rx_q[i] !== exp_q[i]) ok = 0;
      chk_cnt++; if (!ok) $display("FAIL rnd%0d_rx: got %0d bytes %p want %p", t, rx_q.size(), rx_q, exp_q); else pass_cnt++;
      chk_cnt++; if ({rx_rw, byte_count} !== {m_rw, m_count})
        $display("FAIL rnd%0d_rw_count: got %b %0d want %b %0d", t, rx_rw, byte_count, m_rw, m_count);
      else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL rnd%0d_busy: got %b want 0", t, busy); else pass_cnt++;
      $display("txn rnd%0d addr=%h nbytes=%0d acks=%0d rx=%0d", t, addr_b, n, ack_cnt, rx_q.size());
    end
  endtask

  task automatic test_glitch();
    logic [7:0] b;
    logic [7:0] exp_b;
    logic       a0, a1;
    b = 8'hA5;
    exp_b = 8'hB2;
`ifdef I2C_SLAVE_RX_GLITCH_FILTER_EN
    exp_b = 8'hA5;
`endif
    rx_q.delete();
    bus_start();
    bus_byte(8'hA0, a0);
    for (int i = 7; i >= 0; i--) begin
      if (i == 5) begin
        sda_drv = b[i]; cyc(Q); scl_drv = 1'b1; cyc(4);
        scl_drv = 1'b0; cyc(2); scl_drv = 1'b1; cyc(2*Q - 6);
        scl_drv = 1'b0; cyc(Q);
      end else begin
        bus_bit(b[i]);
      end
    end
    bus_ack(a1);
    bus_stop();
    chk_cnt++; if (a0 !== 1'b1) $display("FAIL gl_addr_ack: got %b want 1", a0); else pass_cnt++;
    chk_cnt++; if (rx_q.size() < 1 || rx_q[0] !== exp_b)
      $display("FAIL gl_rx: got %0d bytes first %h want %h", rx_q.size(), rx_q[0], exp_b);
    else pass_cnt++;
    $display("txn glitch addr=a0 data=a5 rx0=%h", rx_q[0]);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_write();
    test_addr_mismatch();
    test_read_addr();
    test_repeated_start();
    test_reset_mid();
    test_random();
    test_glitch();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/i2c_slave_rx.md
# i2c_slave_rx

Oversampled I2C receive-side slave that consumes the SCL/SDA lines produced by the team's I2C master. It detects START/STOP, matches a 7-bit address, shifts in data bytes, and drives ACK through an open-drain enable. Parallel bytes are presented to downstream logic as single-cycle strobes. It sits on the same bus as the master, one stage downstream, and is clocked by a system clock faster than SCL.

## Interface

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit address this block responds to.
- SYNC_STAGES, 2, synchronizer flops on scl_in/sda_in (legal 2..4).

Ports:
- clk  input  1  system clock; every flop is on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- scl_in  input  1  bus SCL, asynchronous to clk.
- sda_in  input  1  bus SDA, asynchronous to clk.
- sda_oe  output  1  1 = pull SDA low (ACK); 0 = release.
- rx_data  output  8  last received data byte, MSB first on the wire.
- rx_valid  output  1  one-cycle strobe; rx_data is valid on this cycle.
- rx_rw  output  1  R/W bit of the last matched address byte.
- addr_match  output  1  high from address ACK until STOP or repeated START.
- busy  output  1  high between START and STOP.
- start_det  output  1  one-cycle pulse per START/repeated START.
- stop_det  output  1  one-cycle pulse per STOP.
- byte_count  output  8  data bytes received since the last matched address; saturates at 255.

## Operation

- scl_in and sda_in pass through SYNC_STAGES flops. Edges are detected by comparing the synced value with a 1-cycle-delayed copy.
- START: falling edge of SDA while SCL is high. STOP: rising edge of SDA while SCL is high. Both are checked before any state logic and override it.
- Data bits are sampled on the detected SCL rising edge.
- FSM states: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
  - IDLE -> ADDR on START. Bit counter = 7; busy = 1.
  - ADDR: shifts in 8 bits. After the 8th rising edge:
    - if bits[7:1] == SLAVE_ADDR: latch rx_rw = bit0, clear byte_count, set addr_match, go to ADDR_ACK;
    - otherwise go to IGNORE.
  - ADDR_ACK: sda_oe = 1 from the next SCL falling edge until the following SCL falling edge (the 9th clock), then -> DATA.
  - DATA: shifts in 8 bits regardless of rx_rw. After the 8th rising edge: update rx_data, pulse rx_valid, increment byte_count (saturating), go to DATA_ACK.
  - DATA_ACK: same sda_oe window as ADDR_ACK, then -> DATA.
  - IGNORE: sda_oe = 0. Exits only on START or STOP.
- STOP in any state -> IDLE. It clears busy, addr_match and sda_oe. A partial byte is discarded with no rx_valid.
- START in any non-IDLE state (repeated START) -> ADDR. It clears addr_match and sda_oe and restarts the bit counter. byte_count holds its value until the next address match.
- The block never drives SDA except in the ACK windows.
- reset_n low, at any time: all outputs go to 0 asynchronously, the FSM goes to IDLE and the synchronizers are set to 1 (idle bus). This holds mid-byte too.

## Timing

- Pin-to-detect latency: SYNC_STAGES cycles (+2 with the filter enabled).
- rx_valid, start_det and stop_det are asserted 1 cycle after the corresponding detected event, for exactly 1 cycle.
- sda_oe changes 1 cycle after the detected SCL falling edge.
- SCL high and low phases must each be at least SYNC_STAGES+3 clk cycles (SYNC_STAGES+5 with the filter). Shorter phases are unsupported.
- START and STOP detected on the same cycle as an SCL edge: START/STOP wins and the bit is not sampled.

## Configuration

- I2C_SLAVE_RX_GLITCH_FILTER_EN defined: after synchronization, each line passes a 3-sample filter. The filtered value changes only after 3 consecutive equal samples, so pulses of 2 cycles or fewer are rejected. This adds 2 cycles of latency.
- Not defined: synchronizer outputs feed edge detection directly, and a 1-cycle glitch can be seen as an edge.

## Test plan

- START, address 0x50 + W, data 0xAA, STOP -> start_det 1 pulse; sda_oe high for the 9th clock twice; rx_data = 0xAA with 1 rx_valid pulse; byte_count = 1; stop_det 1 pulse; busy back to 0.
- Address 0x51 + W, data 0x12 -> no sda_oe, no rx_valid, addr_match stays 0, FSM returns to IDLE on STOP.
- Address 0x50 + R (0xA1), then bytes 0x01, 0x02 -> rx_rw = 1; two rx_valid pulses with 0x01 then 0x02; byte_count = 2.
- Repeated START after 4 data bits, then 0x50 + W, 0x5A -> partial byte dropped; second start_det pulse; rx_data = 0x5A.
- reset_n low during bit 5 of a data byte -> all outputs 0 immediately. After release, a full transaction with 0xC3 completes normally.
- With I2C_SLAVE_RX_GLITCH_FILTER_EN: a 2-cycle low glitch on SCL mid-byte -> no extra bit sampled, byte received intact. Without the macro: the byte is corrupted, which is the expected result.
